cnv_array: RTL
==============

// Module: cnv_array
// PURPOSE
//  Streaming 3x3 convolution engine: NUM_CH parallel output channels over one raster-order 8-bit image.
//  - Builds the zero-padded 3x3 window internally from two line buffers; no external 72-bit window feed.
//  - Holds per-channel weights loaded through a write port.
//  - Each lane quantises its accumulator to 8 bits, in wrap or saturate mode.
//  - Sits between the image source (hex/BMP reader or DMA) and the per-channel bmp_image_writer sinks.
// PARAMETERS
//  NUM_CH    16   number of output channels / MAC lanes
//  WIDTH     128  image width in pixels (>=3)
//  HEIGHT    128  image height in pixels (>=3)
//  DW        8    pixel width, unsigned
//  WW        8    weight width, signed two's complement
//  ACC_W     20   accumulator width, signed; must be >= DW+WW+4
//  OUT_SHIFT 12   arithmetic right shift applied before quantisation
// PORTS
//  clk         in   1            clock
//  rstn        in   1            reset; one clock, synchronous, active-high (port name kept per codebase)
//  start       in   1            pulse: begin a frame (honoured in IDLE only)
//  quant_mode  in   1            0 = wrap (acc>>>OUT_SHIFT low 8 bits); 1 = ReLU + clip to [0,255]
//  w_we        in   1            weight write strobe (honoured in IDLE only)
//  w_ch        in   log2(NUM_CH) target channel
//  w_idx       in   4            tap index 0..8, raster order (4 = centre)
//  w_data      in   WW           signed weight
//  in_vld      in   1            input pixel valid
//  in_data     in   DW           input pixel, raster order
//  in_rdy      out  1            input accept; transfer when in_vld & in_rdy
//  out_vld     out  1            output beat valid (no backpressure)
//  out_data    out  NUM_CH*8     channel k in [8k+7:8k]
//  frame_done  out  1            1-cycle pulse coincident with final out_vld of frame
//  busy        out  1            high in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters, line buffers, window and weights cleared to 0.
//  FSM
//   - IDLE -start-> RUN.
//   - RUN: in_rdy=1; after the WIDTH*HEIGHT-th accepted pixel -> FLUSH.
//   - FLUSH: in_rdy=0; WIDTH+1 internal beats, one per cycle, each injecting a zero pixel -> DRAIN.
//   - DRAIN: wait for the pipeline to empty (3 cycles) -> IDLE.
//  Window
//   - Output centre (r,c) completes on the beat carrying pixel index (r+1)*WIDTH+c+1 (accepted or flush).
//   - Taps outside the image (r-1<0, r+1>=HEIGHT, c-1<0, c+1>=WIDTH) are forced to 0.
//   - Row/column wrap: a row's left taps never see the previous row's right-edge pixels.
//   - The first WIDTH+1 beats of a frame produce no output.
//  Pipeline and latency
//   - Three stages: window register -> MAC register -> quant register.
//   - out_vld is exactly 3 cycles after the completing beat.
//   - Exactly WIDTH*HEIGHT out_vld beats per frame, in raster order.
//   - Input gaps (in_vld low) insert bubbles only; results are unchanged.
//  Arithmetic
//   - Lane product: signed(pixel zero-extended) * w.
//   - Lane sum: the 9 products summed at ACC_W signed; no overflow by the width rule.
//   - q = acc >>> OUT_SHIFT.
//   - Mode 0: out = q[7:0].
//   - Mode 1: out = q<0 ? 0 : (q>255 ? 255 : q).
//   - quant_mode is sampled into the quant stage every cycle; callers hold it stable per frame.
//  Simultaneous and abnormal events
//   - w_we and start in the same IDLE cycle: the write lands and is used by that frame.
//   - w_we or start outside IDLE: ignored; weights and state unchanged.
//   - rstn mid-frame: frame abandoned; no further out_vld or frame_done; weights cleared.
// STRUCTURE
//  Package cnv_pkg:
//   - state enum {IDLE, RUN, FLUSH, DRAIN}.
//   - TAPS=9 and quant mode constants QM_WRAP=0, QM_SAT=1.
//   - Function clog2 for counter widths.
//  Sub-module cnv_mac_lane, one instance per channel:
//   - Inputs: 72-bit window, 9 weights, quant_mode.
//   - Contains the MAC register and quant register; output is 8 bits.
//  Top level holds:
//   - FSM; row/col counters for the input and centre positions.
//   - Two WIDTH x DW line buffers and the window shift register.
//   - Padding mask, weight register file, frame_done generation.
// TESTING (bench: WIDTH=HEIGHT=4, NUM_CH=2, OUT_SHIFT=0)
//  - Identity kernel (w4=1, rest 0), mode 1, ramp 0..15 ->
//    16 out_vld equal to 0..15; frame_done with the 16th beat; in_rdy low for exactly 5 FLUSH cycles.
//  - All-ones kernel, all pixels 10, mode 1 ->
//    corners 40, edges 60, interior 90.
//  - All -1 kernel, all pixels 10 ->
//    mode 1: all 0; mode 0: interior 0xA6, corners 0xD8.
//  - Ch0 identity, ch1 all-ones; w_we to ch0 during RUN ->
//    write ignored; ch0 still identity; ch1 independent and correct.
//  - Random in_vld gaps (about 50% duty) ->
//    bit-identical outputs to the gap-free run; out_vld count = 16.
//  - rstn asserted at beat 7, then a fresh start and frame ->
//    no stale out_vld; weights read 0 until reloaded; second frame correct.

Source files
------------

// File: rtl/cnv_pkg.sv
// Shared types and constants for the streaming 3x3 convolution array.
package cnv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int   TAPS    = 9;
  localparam logic QM_WRAP = 1'b0;
  localparam logic QM_SAT  = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cnv_mac_lane.sv
// One output channel: 9-tap signed MAC register followed by the 8-bit quantiser register.
module cnv_mac_lane
  import cnv_pkg::*;
#(
  parameter int DW        = 8,
  parameter int WW        = 8,
  parameter int ACC_W     = 20,
  parameter int OUT_SHIFT = 12
) (
  input  logic                 clk,
  input  logic                 i_srst,
  input  logic [TAPS*DW-1:0]   i_win,
  input  logic [TAPS*WW-1:0]   i_wts,
  input  logic                 i_quant_mode,
  output logic [7:0]           o_data
);

  logic signed [ACC_W-1:0] w_prod [TAPS];
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_q;
  logic        [7:0]       w_quant;
  logic signed [ACC_W-1:0] r_acc;
  logic        [7:0]       r_q;

  // Both operands are widened to ACC_W first so the product is exact in ACC_W bits.
  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
      logic signed [ACC_W-1:0] w_px;
      logic signed [ACC_W-1:0] w_wt;
      assign w_px       = {{(ACC_W-DW){1'b0}}, i_win[gi*DW +: DW]};
      assign w_wt       = {{(ACC_W-WW){i_wts[gi*WW+WW-1]}}, i_wts[gi*WW +: WW]};
      assign w_prod[gi] = w_px * w_wt;
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < TAPS; i++) begin
      w_sum = w_sum + w_prod[i];
    end
  end

  assign w_q = r_acc >>> OUT_SHIFT;

  always_comb begin
    w_quant = w_q[7:0];
    if (i_quant_mode == QM_SAT) begin
      if (w_q[ACC_W-1])        w_quant = 8'd0;
      else if (|w_q[ACC_W-1:8]) w_quant = 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (i_srst) begin
      r_acc <= '0;
      r_q   <= '0;
    end else begin
      r_acc <= w_sum;
      r_q   <= w_quant;
    end
  end

  assign o_data = r_q;

endmodule

// File: rtl/cnv_array.sv
// Streaming 3x3 convolution: builds a zero-padded window from two line buffers and feeds NUM_CH MAC lanes.
module cnv_array
  import cnv_pkg::*;
#(
  parameter  int NUM_CH    = 16,
  parameter  int WIDTH     = 128,
  parameter  int HEIGHT    = 128,
  parameter  int DW        = 8,
  parameter  int WW        = 8,
  parameter  int ACC_W     = 20,
  parameter  int OUT_SHIFT = 12,
  localparam int CHW       = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  quant_mode,
  input  logic                  w_we,
  input  logic [CHW-1:0]        w_ch,
  input  logic [3:0]            w_idx,
  input  logic [WW-1:0]         w_data,
  input  logic                  in_vld,
  input  logic [DW-1:0]         in_data,
  output logic                  in_rdy,
  output logic                  out_vld,
  output logic [NUM_CH*8-1:0]   out_data,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int            CW       = clog2(WIDTH);
  localparam int            RW       = clog2(HEIGHT + 2);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] ROW_END  = RW'(HEIGHT + 1);

  state_t              r_state, w_state_next;
  logic [1:0]          r_drain;
  logic [RW-1:0]       r_row;
  logic [CW-1:0]       r_col;
  logic [DW-1:0]       r_lb0 [WIDTH];
  logic [DW-1:0]       r_lb1 [WIDTH];
  logic [DW-1:0]       r_win [TAPS];
  logic [3:0]          r_edge;
  logic                r_win_vld, r_win_last, r_mac_vld, r_mac_last, r_out_vld, r_frame_done;
  logic signed [WW-1:0] r_wts [NUM_CH][TAPS];

  logic                w_beat;
  logic [DW-1:0]       w_pix;
  logic                w_in_last, w_flush_last;
  logic [RW-1:0]       w_ctr_row;
  logic [CW-1:0]       w_ctr_col;
  logic                w_ctr_vld, w_ctr_last;
  logic [TAPS*DW-1:0]  w_win;

  always_ff @(posedge clk) begin
    if (rstn) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_rdy       = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = RUN;
      end
      RUN: begin
        in_rdy = 1'b1;
        if (in_vld && w_in_last) w_state_next = FLUSH;
      end
      FLUSH: if (w_flush_last) w_state_next = DRAIN;
      DRAIN: if (r_drain == 2'd2) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_beat       = ((r_state == RUN) && in_vld) || (r_state == FLUSH);
  assign w_pix        = (r_state == RUN) ? in_data : '0;
  assign w_in_last    = (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_flush_last = (r_row == ROW_END) && (r_col == '0);

  // The centre trails the incoming pixel by one row and one column; column 0 wraps to the previous row.
  assign w_ctr_col  = (r_col == '0) ? COL_LAST : r_col - 1'b1;
  assign w_ctr_row  = (r_col == '0) ? r_row - RW'(2) : r_row - RW'(1);
  assign w_ctr_vld  = (r_row >= RW'(2)) || ((r_row == RW'(1)) && (r_col != '0));
  assign w_ctr_last = w_flush_last;

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_row   <= '0;
      r_col   <= '0;
      r_drain <= '0;
    end else begin
      if ((r_state == IDLE) && start) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_beat) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      r_drain <= (r_state == DRAIN) ? r_drain + 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_lb0[i] <= '0;
        r_lb1[i] <= '0;
      end
      for (int i = 0; i < TAPS; i++) r_win[i] <= '0;
      r_edge     <= '0;
      r_win_vld  <= 1'b0;
      r_win_last <= 1'b0;
    end else begin
      r_win_vld  <= w_beat && w_ctr_vld;
      r_win_last <= w_beat && w_ctr_vld && w_ctr_last;
      if (w_beat) begin
        r_lb0[r_col] <= w_pix;
        r_lb1[r_col] <= r_lb0[r_col];
        for (int rr = 0; rr < 3; rr++) begin
          r_win[rr*3]   <= r_win[rr*3+1];
          r_win[rr*3+1] <= r_win[rr*3+2];
        end
        r_win[2] <= r_lb1[r_col];
        r_win[5] <= r_lb0[r_col];
        r_win[8] <= w_pix;
        r_edge   <= {w_ctr_row == '0, w_ctr_row == ROW_LAST, w_ctr_col == '0, w_ctr_col == COL_LAST};
      end
    end
  end

  // r_edge = {top, bottom, left, right}; the left mask also hides the previous row's right edge.
  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_mask
      localparam int TR = gi / 3;
      localparam int TC = gi % 3;
      logic w_kill;
      assign w_kill = ((TR == 0) && r_edge[3]) || ((TR == 2) && r_edge[2]) ||
                      ((TC == 0) && r_edge[1]) || ((TC == 2) && r_edge[0]);
      assign w_win[gi*DW +: DW] = w_kill ? '0 : r_win[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int t = 0; t < TAPS; t++) r_wts[c][t] <= '0;
      end
    end else if ((r_state == IDLE) && w_we && (w_idx < 4'd9) && (int'(w_ch) < NUM_CH)) begin
      r_wts[w_ch][w_idx] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_mac_vld    <= 1'b0;
      r_mac_last   <= 1'b0;
      r_out_vld    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_mac_vld    <= r_win_vld;
      r_mac_last   <= r_win_last;
      r_out_vld    <= r_mac_vld;
      r_frame_done <= r_mac_last;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
      logic [TAPS*WW-1:0] w_wts;
      for (genvar gj = 0; gj < TAPS; gj++) begin : g_wt
        assign w_wts[gj*WW +: WW] = r_wts[gi][gj];
      end
      cnv_mac_lane #(
        .DW        (DW),
        .WW        (WW),
        .ACC_W     (ACC_W),
        .OUT_SHIFT (OUT_SHIFT)
      ) u_lane (
        .clk          (clk),
        .i_srst       (rstn),
        .i_win        (w_win),
        .i_wts        (w_wts),
        .i_quant_mode (quant_mode),
        .o_data       (out_data[gi*8 +: 8])
      );
    end
  endgenerate

  assign out_vld    = r_out_vld;
  assign frame_done = r_frame_done;

endmodule
